// File: rtl/bsg_mem_ctrl_pkg.sv
// Shared constants and request bundle for the
// 512x64 byte-masked memory request front-end.
package bsg_mem_ctrl_pkg;

  localparam int width_def_c      = 64;
  localparam int els_def_c        = 512;
  localparam int rsp_els_def_c    = 3;
  localparam int addr_width_def_c = $clog2(els_def_c);
  localparam int mask_width_def_c = width_def_c >> 3;

  typedef struct packed {
    logic                        w;
    logic [addr_width_def_c-1:0] addr;
    logic [width_def_c-1:0]      data;
    logic [mask_width_def_c-1:0] mask;
  } mem_req_t;

endpackage

// File: rtl/hard_mem_1rw_byte_mask_d512_w64_req_ctrl_if.sv
// Request, response and memory-pin bundle of the
// request front-end; slave is the controller side.
interface hard_mem_1rw_byte_mask_d512_w64_req_ctrl_if
  import bsg_mem_ctrl_pkg::*;
#(
  parameter int width_p = width_def_c,
  parameter int els_p   = els_def_c
);

  localparam int addr_width_lp = $clog2(els_p);
  localparam int mask_width_lp = width_p >> 3;

  logic                     v_i;
  logic                     ready_o;
  logic                     w_i;
  logic [addr_width_lp-1:0] addr_i;
  logic [width_p-1:0]       data_i;
  logic [mask_width_lp-1:0] write_mask_i;
  logic                     v_o;
  logic [width_p-1:0]       data_o;
  logic                     yumi_i;
  logic                     mem_v_o;
  logic                     mem_w_o;
  logic [addr_width_lp-1:0] mem_addr_o;
  logic [width_p-1:0]       mem_data_o;
  logic [mask_width_lp-1:0] mem_write_mask_o;
  logic [width_p-1:0]       mem_data_i;

  modport slave (
    input  v_i, w_i, addr_i, data_i,
    input  write_mask_i, yumi_i, mem_data_i,
    output ready_o, v_o, data_o,
    output mem_v_o, mem_w_o, mem_addr_o,
    output mem_data_o, mem_write_mask_o
  );

  modport master (
    output v_i, w_i, addr_i, data_i,
    output write_mask_i, yumi_i, mem_data_i,
    input  ready_o, v_o, data_o,
    input  mem_v_o, mem_w_o, mem_addr_o,
    input  mem_data_o, mem_write_mask_o
  );

endinterface

// File: rtl/hard_mem_req_ctrl_rsp_fifo.sv
// Circular response FIFO with head/tail pointers
// and an occupancy counter.
module hard_mem_req_ctrl_rsp_fifo
  import bsg_mem_ctrl_pkg::*;
#(
  parameter  int width_p  = width_def_c,
  parameter  int els_p    = rsp_els_def_c,
  localparam int cnt_w_lp = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                push_i,
  input  logic [width_p-1:0]  data_i,
  input  logic                pop_i,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  output logic [cnt_w_lp-1:0] count_o
);

  localparam int ptr_w_lp = $clog2(els_p);

  logic [ptr_w_lp-1:0] head_q, head_d;
  logic [ptr_w_lp-1:0] tail_q, tail_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                pop;
  logic [width_p-1:0]  mem_q [els_p];

  function automatic logic [ptr_w_lp-1:0] wrap_inc(
    input logic [ptr_w_lp-1:0] p
  );
    return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop = pop_i & (count_q != '0);

  always_comb begin
    head_d  = pop ? wrap_inc(head_q) : head_q;
    tail_d  = push_i ? wrap_inc(tail_q) : tail_q;
    count_d = count_q;
    unique case ({push_i, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // storage is left unreset; v_o qualifies data_o
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[tail_q] <= data_i;
  end

  assign v_o     = (count_q != '0);
  assign data_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/hard_mem_1rw_byte_mask_d512_w64_req_ctrl.sv
// Request front-end for the 512x64 byte-masked memory:
// drives the wrapper pins and buffers late read data.
module hard_mem_1rw_byte_mask_d512_w64_req_ctrl
  import bsg_mem_ctrl_pkg::*;
#(
  parameter int width_p   = width_def_c,
  parameter int els_p     = els_def_c,
  parameter int rsp_els_p = rsp_els_def_c
) (
  input logic clk_i,
  input logic reset_n_i,
  hard_mem_1rw_byte_mask_d512_w64_req_ctrl_if.slave bus
);

  localparam int addr_width_lp = $clog2(els_p);
  localparam int cnt_w_lp      = $clog2(rsp_els_p + 1);

  logic [cnt_w_lp-1:0]      count;
  logic [cnt_w_lp:0]        occ;
  logic                     ready;
  logic                     fire;
  logic                     rd_pend_q, rd_pend_d;
  logic                     rsp_v;
  logic [width_p-1:0]       rsp_data;
  logic [addr_width_lp-1:0] addr;

  // buffered plus in-flight reads must fit in the FIFO
  assign occ   = {1'b0, count} + {{cnt_w_lp{1'b0}}, rd_pend_q};
  assign ready = reset_n_i & (occ < (cnt_w_lp + 1)'(rsp_els_p));
  assign fire  = bus.v_i & ready;
  assign addr  = bus.addr_i;

  always_comb begin
    rd_pend_d            = fire & ~bus.w_i;
    bus.mem_v_o          = fire & (~bus.w_i | (|bus.write_mask_i));
    bus.mem_w_o          = bus.w_i;
    bus.mem_addr_o       = addr;
    bus.mem_data_o       = bus.data_i;
    bus.mem_write_mask_o = bus.write_mask_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) rd_pend_q <= 1'b0;
    else            rd_pend_q <= rd_pend_d;
  end

  hard_mem_req_ctrl_rsp_fifo #(
    .width_p (width_p),
    .els_p   (rsp_els_p)
  ) u_rsp_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (rd_pend_q),
    .data_i    (bus.mem_data_i),
    .pop_i     (bus.yumi_i),
    .v_o       (rsp_v),
    .data_o    (rsp_data),
    .count_o   (count)
  );

  assign bus.ready_o = ready;
  assign bus.v_o     = rsp_v;
  assign bus.data_o  = rsp_data;

endmodule

// File: tb/tb_hard_mem_1rw_byte_mask_d512_w64_req_ctrl.sv
// Scoreboard bench for the memory request front-end,
// with a behavioural 512x64 byte-masked wrapper.
module tb_hard_mem_1rw_byte_mask_d512_w64_req_ctrl;
  import bsg_mem_ctrl_pkg::*;

  localparam int W = 64;
  localparam int D = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hard_mem_1rw_byte_mask_d512_w64_req_ctrl_if #(
    .width_p (W),
    .els_p   (D)
  ) bus ();

  hard_mem_1rw_byte_mask_d512_w64_req_ctrl #(
    .width_p   (W),
    .els_p     (D),
    .rsp_els_p (3)
  ) u_dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  logic [63:0] wmem [D];
  logic [63:0] ref_mem [D];
  logic [63:0] exp_q [$];

  int  cyc = 0;
  int  fires = 0, pops = 0, stalls = 0;
  int  last_pop_cyc = 0, max_out = 0;
  int  cmode = 0;
  bit  tog = 1'b0;
  logic last_mem_v = 1'b0;

  function automatic logic [63:0] seed_word(int i);
    return {16'hC0DE, 16'(i), 32'(i * 7919 + 3)};
  endfunction

  function automatic logic [63:0] merge(
    logic [63:0] old, logic [63:0] d, logic [7:0] m
  );
    logic [63:0] r = old;
    for (int b = 0; b < 8; b++)
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // behavioural wrapper: data valid the cycle after the access
  always @(posedge clk) begin
    if (bus.mem_v_o) begin
      if (bus.mem_w_o)
        wmem[bus.mem_addr_o] <= merge(wmem[bus.mem_addr_o],
                                      bus.mem_data_o,
                                      bus.mem_write_mask_o);
      else
        bus.mem_data_i <= wmem[bus.mem_addr_o];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.yumi_i && !bus.v_o) check("yumi_legal", 1, 0);
      if (bus.v_o && bus.yumi_i) begin
        pops++;
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) check("rsp_extra", 1, 0);
        else check("rsp", bus.data_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    bus.yumi_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tog = ~tog;
      bus.yumi_i = bus.v_o && (cmode == 1 || (cmode == 2 && tog));
      if (fires - pops > max_out) max_out = fires - pops;
    end
  end

  task automatic req(bit w, int a, logic [63:0] d, logic [7:0] m);
    mem_req_t r;
    int tries = 0;
    r = '{w: w, addr: 9'(a), data: d, mask: m};
    bus.v_i          = 1'b1;
    bus.w_i          = r.w;
    bus.addr_i       = r.addr;
    bus.data_i       = r.data;
    bus.write_mask_i = r.mask;
    @(negedge clk);
    while (!bus.ready_o && tries < 200) begin
      stalls++;
      tries++;
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    if (!bus.ready_o) begin
      check("req_timeout", 0, 1);
    end else begin
      last_mem_v = bus.mem_v_o;
      if (w) begin
        ref_mem[r.addr] = merge(ref_mem[r.addr], d, m);
      end else begin
        fires++;
        exp_q.push_back(ref_mem[r.addr]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    bus.v_i = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int t = 0;
    bus.v_i = 1'b0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", 64'(exp_q.size()), 0);
  endtask

  initial begin
    int s0, c0, p0, f0, vhi;
    for (int i = 0; i < D; i++) begin
      wmem[i]    = seed_word(i);
      ref_mem[i] = seed_word(i);
    end
    bus.mem_data_i   = '0;
    bus.v_i          = 1'b1;
    bus.w_i          = 1'b0;
    bus.addr_i       = 9'd3;
    bus.data_i       = '0;
    bus.write_mask_i = '0;

    repeat (2) @(negedge clk);
    check("rst_v_o", bus.v_o, 0);
    check("rst_mem_v", bus.mem_v_o, 0);
    bus.v_i = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_ready", bus.ready_o, 1);
    check("rst_v_o_after", bus.v_o, 0);
    @(posedge clk);
    #1;
    cmode = 1;

    // read-after-write, partial mask
    req(1, 5, 64'h1122334455667788, 8'hFF);
    check("wr_mem_v", last_mem_v, 1);
    req(1, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    req(0, 5, '0, '0);
    bus.v_i = 1'b0;
    @(negedge clk);
    check("raw_lat1", bus.v_o, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("raw_lat2", bus.v_o, 1);
    check("raw_data", bus.data_o, 64'h11223344AAAAAAAA);
    drain();

    // zero-mask write
    req(1, 7, 64'hFFFFFFFFFFFFFFFF, 8'h00);
    check("zm_mem_v", last_mem_v, 0);
    req(0, 7, '0, '0);
    idle(1);
    drain();

    // back-pressure
    cmode = 0;
    f0 = fires;
    req(0, 0, '0, '0);
    req(0, 1, '0, '0);
    req(0, 2, '0, '0);
    fork
      begin
        req(0, 3, '0, '0);
        bus.v_i = 1'b0;
      end
      begin
        repeat (4) @(negedge clk);
        check("bp_ready_low", bus.ready_o, 0);
        check("bp_accepted", 64'(fires - f0), 3);
        check("bp_v_o", bus.v_o, 1);
        cmode = 1;
      end
    join
    drain();
    check("bp_all", 64'(fires - f0), 4);

    // sustained throughput
    s0 = stalls;
    c0 = cyc;
    for (int i = 0; i < 100; i++) req(0, i, '0, '0);
    drain();
    check("tp_stalls", 64'(stalls - s0), 0);
    check("tp_last_cyc", 64'(last_pop_cyc - c0), 101);

    // wrap with alternating pops
    cmode   = 2;
    max_out = 0;
    p0      = pops;
    for (int i = 0; i < 10; i++) req(0, 200 + i, '0, '0);
    drain();
    check("wrap_max", 64'(max_out <= 3), 1);
    check("wrap_cnt", 64'(pops - p0), 10);

    // reset with 2 buffered, 1 pending
    cmode = 0;
    idle(2);
    req(0, 40, '0, '0);
    req(0, 41, '0, '0);
    req(0, 42, '0, '0);
    bus.v_i = 1'b1;
    bus.w_i = 1'b0;
    check("mr_v_before", bus.v_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_v_o", bus.v_o, 0);
    check("mr_mem_v", bus.mem_v_o, 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("mr_mem_v_hold", bus.mem_v_o, 0);
    bus.v_i = 1'b0;
    rst_n = 1'b1;
    #1;
    check("mr_ready", bus.ready_o, 1);
    fires = 0;
    pops  = 0;
    vhi   = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.v_o) vhi++;
    end
    check("mr_stale", 64'(vhi), 0);
    @(posedge clk);
    #1;
    cmode = 1;
    req(0, 40, '0, '0);
    req(0, 5, '0, '0);
    drain();
    check("mr_cnt", 64'(pops), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
